// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message schedule.
// Word/block geometry, FSM encoding and small-sigma rotate/shift amounts.
package sha256_pkg;
  localparam int WORD_W     = 32;
  localparam int WIN_N      = 16;
  localparam int BLOCK_W    = WIN_N * WORD_W;
  localparam int ROUNDS_DEF = 64;
  localparam int T_W        = 6;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  localparam bit SIGMA0 = 1'b0;
  localparam bit SIGMA1 = 1'b1;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction
endpackage

// File: rtl/sha256_small_sigma.sv
// Combinational SHA-256 small sigma; SEL=0 gives s0, SEL=1 gives s1.
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter bit SEL = SIGMA0
) (
  input  word_t i_x,
  output word_t o_y
);
  localparam int ROT_A = SEL ? S1_ROT_A : S0_ROT_A;
  localparam int ROT_B = SEL ? S1_ROT_B : S0_ROT_B;
  localparam int SHR_N = SEL ? S1_SHR   : S0_SHR;

  assign o_y = rotr(i_x, ROT_A) ^ rotr(i_x, ROT_B) ^ (i_x >> SHR_N);
endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: 16-word sliding window emits W0..W(ROUNDS-1), one per unstalled cycle.
// stall_i freezes window, counter and outputs; done_o pulses once after the last word is consumed.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [BLOCK_W-1:0] block_i,
  input  logic               stall_i,
  output logic [WORD_W-1:0]  w_o,
  output logic [T_W-1:0]     t_o,
  output logic               w_valid_o,
  output logic               busy_o,
  output logic               done_o
);
  localparam logic [T_W-1:0] T_LAST = T_W'(ROUNDS - 1);

  state_t         r_state;
  word_t          r_win [WIN_N];
  logic [T_W-1:0] r_t;
  logic           r_valid;
  logic           r_busy;
  logic           r_done;

  word_t w_s0;
  word_t w_s1;
  word_t w_new;

  sha256_small_sigma #(.SEL(SIGMA0)) u_sigma0 (.i_x(r_win[1]),  .o_y(w_s0));
  sha256_small_sigma #(.SEL(SIGMA1)) u_sigma1 (.i_x(r_win[14]), .o_y(w_s1));

  assign w_new = w_s1 + r_win[9] + w_s0 + r_win[0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < WIN_N; i++) r_win[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < WIN_N; i++)
              r_win[i] <= block_i[BLOCK_W-1-WORD_W*i -: WORD_W];
            r_t     <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!stall_i) begin
            // The last word leaves the window untouched so w_o keeps showing it.
            if (r_t == T_LAST) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              for (int i = 0; i < WIN_N - 1; i++) r_win[i] <= r_win[i+1];
              r_win[WIN_N-1] <= w_new;
              r_t            <= r_t + T_W'(1);
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_o       = r_win[0];
  assign t_o       = r_t;
  assign w_valid_o = r_valid;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized bench for sha256_msg_schedule against a textbook SHA-256 schedule model.
module tb_sha256_msg_schedule;
  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic [511:0] block_i;
  logic         stall_i;
  logic [31:0]  w_o;
  logic [5:0]   t_o;
  logic         w_valid_o;
  logic         busy_o;
  logic         done_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_w [64];

  sha256_msg_schedule dut (
    .CLK(CLK), .RST(RST), .start(start), .block_i(block_i), .stall_i(stall_i),
    .w_o(w_o), .t_o(t_o), .w_valid_o(w_valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  task automatic build_model(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) model_w[t] = blk[511-32*t -: 32];
      else begin
        s0 = rr(model_w[t-15], 7) ^ rr(model_w[t-15], 18) ^ (model_w[t-15] >> 3);
        s1 = rr(model_w[t-2], 17) ^ rr(model_w[t-2], 19) ^ (model_w[t-2] >> 10);
        model_w[t] = s1 + model_w[t-7] + s0 + model_w[t-16];
      end
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  // Compare process: every valid cycle must present the next model word in order.
  int          idx = 0;
  bit          in_blk = 1'b0;
  bit          prev_stalled = 1'b0;
  logic [31:0] prev_w;
  logic [5:0]  prev_t;

  always @(negedge CLK) begin
    if (w_valid_o) begin
      if (!in_blk) begin
        in_blk = 1'b1;
        idx    = 0;
      end
      if (idx < 64) begin
        chk("t_o_seq", 32'(t_o), 32'(idx));
        chk("w_o_seq", w_o, model_w[idx]);
      end else chk("idx_overrun", 32'(idx), 32'd63);
      if (prev_stalled) begin
        chk("stall_hold_w", w_o, prev_w);
        chk("stall_hold_t", 32'(t_o), 32'(prev_t));
      end
      prev_stalled = stall_i;
      prev_w       = w_o;
      prev_t       = t_o;
      if (!stall_i) idx++;
    end else begin
      in_blk       = 1'b0;
      prev_stalled = 1'b0;
    end
    if (done_o) chk("done_after_last", 32'(idx), 32'd64);
  end

  task automatic run_block(input logic [511:0] blk, input int stall_pct, input bit inject,
                           output int cyc, output int nstall, output logic [31:0] first_w);
    bit done_seen = 1'b0;
    bit injected  = 1'b0;
    build_model(blk);
    block_i = blk;
    start   = 1'b1;
    @(posedge CLK); #1;
    start   = 1'b0;
    block_i = ~blk;
    first_w = w_o;
    chk("first_t", 32'(t_o), 32'd0);
    chk("first_valid", 32'(w_valid_o), 32'd1);
    cyc    = 0;
    nstall = 0;
    for (int k = 0; k < 600 && !done_seen; k++) begin
      if (busy_o) cyc++;
      if (done_o) done_seen = 1'b1;
      stall_i = ($urandom_range(0, 99) < stall_pct);
      if (w_valid_o && stall_i) nstall++;
      start = 1'b0;
      if (inject && w_valid_o && t_o == 6'd30 && !injected) begin
        start    = 1'b1;
        block_i  = rand_block();
        injected = 1'b1;
      end
      if (inject && done_o) begin
        start   = 1'b1;
        block_i = rand_block();
      end
      @(posedge CLK); #1;
    end
    start   = 1'b0;
    stall_i = 1'b0;
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("idle_after_done", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int          cyc, nst, found;
    logic [31:0] fw;
    logic [511:0] abc;

    RST = 1'b1; start = 1'b0; stall_i = 1'b0; block_i = '0;
    for (int i = 0; i < 3; i++) begin @(posedge CLK); #1; end
    chk("rst_w", w_o, 32'd0);
    chk("rst_t", 32'(t_o), 32'd0);
    chk("rst_valid", 32'(w_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    abc = {32'h61626380, {14{32'h0}}, 32'h00000018};
    run_block(abc, 0, 1'b0, cyc, nst, fw);
    chk("abc_W0", fw, 32'h61626380);
    chk("abc_busy_cycles", 32'(cyc), 32'd65);
    chk("model_W15", model_w[15], 32'h00000018);
    chk("model_W16", model_w[16], 32'h61626380);
    chk("model_W17", model_w[17], 32'h000F0000);
    chk("hold_last_w", w_o, model_w[63]);

    run_block('0, 0, 1'b0, cyc, nst, fw);
    chk("zero_W0", fw, 32'd0);
    chk("zero_busy_cycles", 32'(cyc), 32'd65);
    chk("model_zero_W63", model_w[63], 32'd0);

    for (int b = 0; b < 4; b++) begin
      run_block(rand_block(), 30, 1'b0, cyc, nst, fw);
      chk("stall_busy_cycles", 32'(cyc), 32'(65 + nst));
    end

    run_block(rand_block(), 20, 1'b1, cyc, nst, fw);
    chk("inject_busy_cycles", 32'(cyc), 32'(65 + nst));

    build_model(rand_block());
    block_i = {model_w[0], model_w[1], model_w[2], model_w[3], model_w[4], model_w[5],
               model_w[6], model_w[7], model_w[8], model_w[9], model_w[10], model_w[11],
               model_w[12], model_w[13], model_w[14], model_w[15]};
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      if (w_valid_o && t_o == 6'd20) found = 1;
      else begin @(posedge CLK); #1; end
    end
    chk("reach_t20", 32'(found), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("midrst_w", w_o, 32'd0);
    chk("midrst_t", 32'(t_o), 32'd0);
    chk("midrst_valid", 32'(w_valid_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    run_block(rand_block(), 10, 1'b0, cyc, nst, fw);
    chk("restart_busy_cycles", 32'(cyc), 32'(65 + nst));

    RST = 1'b1; start = 1'b1; block_i = rand_block();
    @(posedge CLK); #1;
    RST = 1'b0; start = 1'b0;
    chk("rst_start_valid", 32'(w_valid_o), 32'd0);
    chk("rst_start_busy", 32'(busy_o), 32'd0);
    @(posedge CLK); #1;
    chk("rst_start_idle_valid", 32'(w_valid_o), 32'd0);
    chk("rst_start_idle_busy", 32'(busy_o), 32'd0);
    chk("rst_start_w", w_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Message-schedule stage of the SHA-256 core. Sits directly upstream of the round datapath and its working registers A..H.
- Accepts one padded 512-bit block and emits the 64 schedule words W0..W63, one per advancing cycle, with round index.
- Holds a 16-word sliding window, so only one new word is computed per cycle; no 64-word RAM.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block (fixed by SHA-256; exposed only for bench shortening, legal range 16..64).
- WORD_W, 32, word width (fixed at 32; not to be overridden).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  load block_i and begin; sampled only in IDLE.
- block_i  in  512  padded message block; word 0 = block_i[511:480], word 15 = block_i[31:0].
- stall_i  in  1  downstream hold; freezes window, counter and outputs.
- w_o  out  32  current schedule word W_t.
- t_o  out  6  current round index t.
- w_valid_o  out  1  w_o/t_o valid (high throughout RUN, including stalled cycles).
- busy_o  out  1  high in RUN and DONE.
- done_o  out  1  one-cycle pulse after W(ROUNDS-1) is consumed.

Behaviour:
- Reset: synchronous, active-high, priority over all inputs, including mid-RUN. Clears all state. State = IDLE, window = 0, counter = 0. All outputs 0: w_o, t_o, w_valid_o, busy_o, done_o.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads win[0..15] = block words 0..15, t=0, and moves to RUN.
  - start=0 holds.
- RUN:
  - w_o = win[0], t_o = t, w_valid_o = 1.
  - Latency: start at edge N gives W0 valid in cycle N+1.
  - stall_i=1: no state change; w_o and t_o stay stable.
  - stall_i=0: the word is consumed. Window shifts: win[i] <= win[i+1] for i = 0..14, and win[15] <= Wnew. Then t <= t+1.
  - Wnew = s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32, with carries discarded.
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - ROTR is a 32-bit rotate; SHR is a logical shift with zero fill.
  - Consuming t = ROUNDS-1 moves to DONE. The counter does not wrap past ROUNDS-1. Wnew computed on that cycle is discarded and has no effect.
- DONE:
  - done_o = 1 for exactly one cycle, w_valid_o = 0, busy_o = 1.
  - Unconditionally moves to IDLE next cycle.
- start outside IDLE is ignored. There is no restart mid-block, and block_i is not re-sampled.
- stall_i in IDLE or DONE has no effect.
- Simultaneous start and RST: RST wins, and the block is not loaded.
- w_o holds its last value in IDLE and DONE, except after reset when it is 0. Consumers must qualify w_o with w_valid_o.

Decomposition:
- Package sha256_pkg:
  - WORD_W.
  - ROUNDS default.
  - Typedef word_t (32-bit).
  - State enum {IDLE, RUN, DONE}.
  - Rotate amounts for s0/s1 as named constants (7/18/3 and 17/19/10).
- Sub-module sha256_small_sigma:
  - Combinational.
  - Parameter SEL selects s0 or s1.
  - Instantiated twice.
- Window, counter and FSM stay in the top module.

Test Plan:
- "abc" block (block_i word0 = 0x61626380, words 1-14 = 0, word15 = 0x00000018), no stall.
  - W0 = 0x61626380 at cycle N+1, W15 = 0x00000018.
  - W16 = 0x61626380, W17 = 0x000F0000.
  - All 64 words match the golden model; done_o pulses one cycle after t = 63.
- All-zero block -> every W_t = 0x00000000, t_o runs 0..63 contiguously, busy_o high 65 cycles.
- Random stall_i pattern (~30%) on random blocks:
  - Word sequence identical to the no-stall run.
  - w_o/t_o stable on every stalled cycle.
  - Total cycles = 64 + stall count + 1.
- start pulsed with a different block_i during RUN and during DONE -> ignored; output sequence unchanged.
- RST asserted at t = 20, then start issued next cycle:
  - All outputs 0 the cycle after RST.
  - New block restarts cleanly at t = 0 with correct words.
- start and RST asserted in the same cycle -> FSM stays IDLE, w_valid_o = 0.
